sg_req_arbiter: RTL and testbench
=================================

// Module: sg_req_arbiter
// PURPOSE
// - Shares one RX-engine read-request channel among C_NUM_REQ scatter-gather list requesters (RX/TX SG lists of several channels).
// - Round-robin grant; forwards the winner's addr/len downstream and returns the request ack to the winner only.
// - Records each issued request's owner in a tag FIFO and routes in-order completions (RX_DONE) back to that owner.
// - Sits between the per-channel sg_list_requester instances and the RX engine request port.
// PARAMETERS
// - C_NUM_REQ    4  number of requesters (2..16)
// - C_TAG_DEPTH  8  max outstanding issued-but-not-done requests; power of 2
// - C_IDX_WIDTH  clog2(C_NUM_REQ)    requester index width (local)
// - C_CNT_WIDTH  clog2(C_TAG_DEPTH+1) outstanding count width (local)
// PORTS
// - CLK         in   1              clock; all logic on posedge
// - RST_N       in   1              synchronous, active-low reset
// - REQ         in   C_NUM_REQ      per-requester read request, held until its REQ_ACK
// - REQ_ADDR    in   64*C_NUM_REQ   per-requester address, slice i = [64*i+63:64*i]
// - REQ_LEN     in   10*C_NUM_REQ   per-requester length in DWs, slice i = [10*i+9:10*i]
// - REQ_ACK     out  C_NUM_REQ      one-cycle pulse: request i accepted downstream
// - REQ_DONE    out  C_NUM_REQ      one-cycle pulse: request of i completed
// - RX_REQ      out  1              request to RX engine
// - RX_ADDR     out  64             registered address of granted request
// - RX_LEN      out  10             registered length of granted request
// - RX_REQ_ACK  in   1              RX engine accepted RX_REQ
// - RX_DONE     in   1              RX engine completed oldest outstanding request (in order)
// - OUTSTANDING out  C_CNT_WIDTH    current tag FIFO occupancy
// - ERR_UNDERFLOW out 1             sticky: RX_DONE seen with no outstanding request
// BEHAVIOUR
// - Reset (RST_N=0 at posedge): state IDLE, RR pointer 0, tag FIFO empty, RX_REQ=0, RX_ADDR=0, RX_LEN=0, OUTSTANDING=0, ERR_UNDERFLOW=0; REQ_ACK/REQ_DONE=0.
// - FSM IDLE: if |REQ and OUTSTANDING<C_TAG_DEPTH -> pick first set REQ[i] searching from pointer upward, wrapping at C_NUM_REQ-1->0; register
//   grant=i, RX_ADDR/RX_LEN from slice i -> ISSUE. If FIFO full, stay IDLE (no grant, REQ held upstream).
// - ISSUE: RX_REQ=1 (state-decoded, no extra latency); RX_ADDR/RX_LEN stable. On RX_REQ_ACK: REQ_ACK[grant]=1 combinationally
//   same cycle, push grant into tag FIFO, pointer<=grant+1 (wraps), -> GAP.
// - GAP: one dead cycle so the winner's REQ deassertion is visible; RX_REQ=0; -> IDLE. Min spacing between issues = 3 cycles.
// - Request is never withdrawn downstream: if REQ[grant] drops while in ISSUE, RX_REQ stays high until RX_REQ_ACK; ack still pushed/pulsed.
// - RX_REQ_ACK outside ISSUE is ignored (no push, no pulse).
// - RX_DONE with FIFO non-empty: REQ_DONE[head]=1 combinationally same cycle, pop head. Empty: no pulse, ERR_UNDERFLOW<=1 (cleared only by reset).
// - Push and pop same cycle: both performed, OUTSTANDING unchanged; push on full cannot occur (grant gated on not-full and only one grant in flight).
// - Pointers of tag FIFO wrap modulo C_TAG_DEPTH; OUTSTANDING = wr-rd difference with extra MSB, range 0..C_TAG_DEPTH.
// - Fairness: a continuously requesting requester waits at most C_NUM_REQ-1 grants.
// - Reset mid-operation: all in-flight tags discarded; later RX_DONE pulses flag ERR_UNDERFLOW (system resets RX engine together).
// STRUCTURE
// - Package sg_arb_pkg: state enum {IDLE, ISSUE, GAP} (one-hot, 3 bits), C_ADDR_W=64, C_LEN_W=10 constants,
//   function rr_pick(req, ptr) returning index and valid.
// - Sub-module sg_arb_tag_fifo: C_TAG_DEPTH x C_IDX_WIDTH register FIFO, push/pop/head/count/empty/full, sync active-low reset.
// - Top: FSM, RR pointer, grant/addr/len registers, ack/done decode, error flag.
// TESTING
// - Single requester 1, addr 0x1000, len 128; ack after 2 cycles -> RX_ADDR=0x1000, RX_LEN=128, REQ_ACK=0010, OUTSTANDING=1; RX_DONE -> REQ_DONE=0010, OUTSTANDING=0.
// - All 4 requesting continuously, ack immediate -> grant order 0,1,2,3,0 ...; issues 3 cycles apart; no starvation over 100 grants.
// - C_TAG_DEPTH=8, no RX_DONE, 10 requests -> exactly 8 acks, RX_REQ stays 0 after 8th; one RX_DONE -> 9th issued.
// - Grants to 2,0,3 then RX_DONE x3 -> REQ_DONE pulses 0100,0001,1000 in that order; RX_DONE coincident with ack -> OUTSTANDING unchanged.
// - RX_DONE with FIFO empty -> no REQ_DONE, ERR_UNDERFLOW=1 until RST_N=0.
// - RST_N low while in ISSUE with 3 outstanding -> next cycle RX_REQ=0, OUTSTANDING=0, pointer 0, all outputs reset values.

Source files
------------

// File: rtl/sg_arb_pkg.sv
// sg_arb_pkg: shared state encoding, bus widths and round-robin pick for the SG request arbiter
package sg_arb_pkg;
  localparam int C_ADDR_W = 64;
  localparam int C_LEN_W = 10;
  typedef enum logic [2:0] {IDLE = 3'b001, ISSUE = 3'b010, GAP = 3'b100} state_t;
  typedef struct packed {logic valid; logic [3:0] idx;} pick_t;
  // First set request at or above ptr, wrapping at n-1; scanning downward lets the nearest one win.
  function automatic pick_t rr_pick(input logic [15:0] req, input logic [3:0] ptr, input int n);
    pick_t p;
    logic [3:0] j;
    p = '0;
    for (int k = 15; k >= 0; k--) begin
      j = 4'((int'(ptr) + k) % n);
      if (k < n && req[j]) begin
        p.valid = 1'b1;
        p.idx = j;
      end
    end
    return p;
  endfunction
endpackage

// File: rtl/sg_arb_tag_fifo.sv
// sg_arb_tag_fifo: in-order owner tags of requests issued downstream but not yet completed
module sg_arb_tag_fifo #(
  parameter int C_DEPTH = 8,
  parameter int C_W = 2
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic [C_W-1:0]               i_din,
  output logic [C_W-1:0]               o_head,
  output logic [$clog2(C_DEPTH+1)-1:0] o_count,
  output logic                         o_empty,
  output logic                         o_full
);
  localparam int C_AW = $clog2(C_DEPTH);
  logic [C_W-1:0] r_mem [C_DEPTH];
  logic [C_AW:0] r_wr, r_rd;
  assign o_count = r_wr - r_rd;
  assign o_empty = r_wr == r_rd;
  assign o_full = o_count == (C_AW + 1)'(C_DEPTH);
  assign o_head = r_mem[r_rd[C_AW-1:0]];
  // Tag storage needs no reset: only slots between the pointers are ever read.
  always_ff @(posedge CLK) begin
    if (i_push) r_mem[r_wr[C_AW-1:0]] <= i_din;
  end
  // Pointers carry an extra MSB so full and empty are distinguishable.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + 1'b1;
      if (i_pop) r_rd <= r_rd + 1'b1;
    end
  end
endmodule

// File: rtl/sg_req_arbiter.sv
// sg_req_arbiter: round-robin share of one RX-engine read-request port with in-order completion routing
module sg_req_arbiter
  import sg_arb_pkg::*;
#(
  parameter int C_NUM_REQ = 4,
  parameter int C_TAG_DEPTH = 8,
  localparam int C_IDX_WIDTH = $clog2(C_NUM_REQ),
  localparam int C_CNT_WIDTH = $clog2(C_TAG_DEPTH + 1)
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic [C_NUM_REQ-1:0]          REQ,
  input  logic [C_ADDR_W*C_NUM_REQ-1:0] REQ_ADDR,
  input  logic [C_LEN_W*C_NUM_REQ-1:0]  REQ_LEN,
  output logic [C_NUM_REQ-1:0]          REQ_ACK,
  output logic [C_NUM_REQ-1:0]          REQ_DONE,
  output logic                          RX_REQ,
  output logic [C_ADDR_W-1:0]           RX_ADDR,
  output logic [C_LEN_W-1:0]            RX_LEN,
  input  logic                          RX_REQ_ACK,
  input  logic                          RX_DONE,
  output logic [C_CNT_WIDTH-1:0]        OUTSTANDING,
  output logic                          ERR_UNDERFLOW
);
  state_t r_state, w_next;
  pick_t w_pick;
  logic [C_IDX_WIDTH-1:0] r_ptr, r_grant, w_idx, w_head;
  logic [C_ADDR_W-1:0] r_addr;
  logic [C_LEN_W-1:0] r_len;
  logic r_err, w_start, w_push, w_pop, w_empty, w_full;
  assign w_pick = rr_pick(16'(REQ), 4'(r_ptr), C_NUM_REQ);
  assign w_idx = C_IDX_WIDTH'(w_pick.idx);
  assign w_start = r_state == IDLE && w_pick.valid && !w_full;
  assign w_push = r_state == ISSUE && RX_REQ_ACK;
  assign w_pop = RX_DONE && !w_empty;
  assign RX_REQ = r_state == ISSUE;
  assign RX_ADDR = r_addr;
  assign RX_LEN = r_len;
  assign ERR_UNDERFLOW = r_err;
  assign REQ_ACK = {{(C_NUM_REQ-1){1'b0}}, w_push} << r_grant;
  assign REQ_DONE = {{(C_NUM_REQ-1){1'b0}}, w_pop} << w_head;
  sg_arb_tag_fifo #(.C_DEPTH(C_TAG_DEPTH), .C_W(C_IDX_WIDTH)) u_tags (
    .CLK(CLK),
    .RST_N(RST_N),
    .i_push(w_push),
    .i_pop(w_pop),
    .i_din(r_grant),
    .o_head(w_head),
    .o_count(OUTSTANDING),
    .o_empty(w_empty),
    .o_full(w_full)
  );
  // Next state: grant only with tag room, hold the request until accepted, then one dead cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: w_next = w_start ? ISSUE : IDLE;
      ISSUE: w_next = RX_REQ_ACK ? GAP : ISSUE;
      default: w_next = IDLE;
    endcase
  end
  // State, grant capture, pointer advance past the winner and sticky underflow flag.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state <= IDLE;
      r_ptr <= '0;
      r_grant <= '0;
      r_addr <= '0;
      r_len <= '0;
      r_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_grant <= w_idx;
        r_addr <= REQ_ADDR[w_idx * C_ADDR_W +: C_ADDR_W];
        r_len <= REQ_LEN[w_idx * C_LEN_W +: C_LEN_W];
      end
      if (w_push) r_ptr <= (r_grant == C_IDX_WIDTH'(C_NUM_REQ - 1)) ? '0 : r_grant + 1'b1;
      if (RX_DONE && w_empty) r_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sg_req_arbiter.sv
// tb_sg_req_arbiter: directed vector table plus multi-cycle sequences for sg_req_arbiter
module tb_sg_req_arbiter;
  localparam int N = 4;
  localparam int D = 8;
  typedef struct {
    logic [3:0] req;
    logic       ack;
    logic       done;
    logic       rx_req;
    logic [3:0] req_ack;
    logic [3:0] req_done;
    logic [3:0] outst;
    logic       err;
    int         g;
  } vec_t;
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic [N-1:0] REQ = '0;
  logic [64*N-1:0] REQ_ADDR;
  logic [10*N-1:0] REQ_LEN;
  logic [N-1:0] REQ_ACK, REQ_DONE;
  logic RX_REQ;
  logic [63:0] RX_ADDR;
  logic [9:0] RX_LEN;
  logic RX_REQ_ACK = 1'b0;
  logic RX_DONE = 1'b0;
  logic [3:0] OUTSTANDING;
  logic ERR_UNDERFLOW;
  int n_tests = 0;
  int n_fail = 0;
  logic [63:0] addrs [N] = '{64'hDEAD_0000_0000_0000, 64'h1000, 64'h2222_0000_0000_2000, 64'hFFFF_FFFF_FFFF_F000};
  logic [9:0] lens [N] = '{10'd1, 10'd128, 10'd1023, 10'd512};
  vec_t tbl [20];

  sg_req_arbiter #(.C_NUM_REQ(N), .C_TAG_DEPTH(D)) dut (
    .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .REQ_ADDR(REQ_ADDR), .REQ_LEN(REQ_LEN),
    .REQ_ACK(REQ_ACK), .REQ_DONE(REQ_DONE), .RX_REQ(RX_REQ), .RX_ADDR(RX_ADDR),
    .RX_LEN(RX_LEN), .RX_REQ_ACK(RX_REQ_ACK), .RX_DONE(RX_DONE),
    .OUTSTANDING(OUTSTANDING), .ERR_UNDERFLOW(ERR_UNDERFLOW)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Holds reset across one edge, checks every output at its reset value, then releases mid-cycle.
  task automatic do_reset(input string tag);
    @(posedge CLK);
    #1;
    RST_N = 1'b0;
    REQ = '0;
    RX_REQ_ACK = 1'b0;
    RX_DONE = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    chk({tag, " rst rx_req"}, 64'(RX_REQ), 64'd0);
    chk({tag, " rst rx_addr"}, RX_ADDR, 64'd0);
    chk({tag, " rst rx_len"}, 64'(RX_LEN), 64'd0);
    chk({tag, " rst outstanding"}, 64'(OUTSTANDING), 64'd0);
    chk({tag, " rst err"}, 64'(ERR_UNDERFLOW), 64'd0);
    chk({tag, " rst acks"}, 64'({REQ_ACK, REQ_DONE}), 64'd0);
    RST_N = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks, grants, last, exp_g;
    logic dn;
    logic [3:0] g;
    for (int i = 0; i < N; i++) begin
      REQ_ADDR[64*i +: 64] = addrs[i];
      REQ_LEN[10*i +: 10] = lens[i];
    end
    //            req     ack  done  rx_req ack      done     out   err  grant
    tbl[0]  = '{4'b0010, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'd0, 1'b0, -1};
    tbl[1]  = '{4'b0010, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 4'd0, 1'b0,  1};
    tbl[2]  = '{4'b0010, 1'b1, 1'b0, 1'b1, 4'b0010, 4'b0000, 4'd0, 1'b0,  1};
    tbl[3]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'd1, 1'b0, -1};
    tbl[4]  = '{4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0010, 4'd1, 1'b0, -1};
    tbl[5]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'd0, 1'b0, -1};
    tbl[6]  = '{4'b0101, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'd0, 1'b0, -1};
    tbl[7]  = '{4'b0101, 1'b1, 1'b0, 1'b1, 4'b0100, 4'b0000, 4'd0, 1'b0,  2};
    tbl[8]  = '{4'b0001, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'd1, 1'b0, -1};
    tbl[9]  = '{4'b0001, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'd1, 1'b0, -1};
    tbl[10] = '{4'b1000, 1'b1, 1'b0, 1'b1, 4'b0001, 4'b0000, 4'd1, 1'b0,  0};
    tbl[11] = '{4'b1000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'd2, 1'b0, -1};
    tbl[12] = '{4'b1000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'd2, 1'b0, -1};
    tbl[13] = '{4'b1000, 1'b1, 1'b1, 1'b1, 4'b1000, 4'b0100, 4'd2, 1'b0,  3};
    tbl[14] = '{4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0001, 4'd2, 1'b0, -1};
    tbl[15] = '{4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b1000, 4'd1, 1'b0, -1};
    tbl[16] = '{4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'd0, 1'b0, -1};
    tbl[17] = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'd0, 1'b1, -1};
    tbl[18] = '{4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'd0, 1'b1, -1};
    tbl[19] = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'd0, 1'b1, -1};

    do_reset("tbl");
    foreach (tbl[i]) begin
      @(posedge CLK);
      #1;
      REQ = tbl[i].req;
      RX_REQ_ACK = tbl[i].ack;
      RX_DONE = tbl[i].done;
      @(negedge CLK);
      chk($sformatf("r%0d rx_req", i), 64'(RX_REQ), 64'(tbl[i].rx_req));
      chk($sformatf("r%0d req_ack", i), 64'(REQ_ACK), 64'(tbl[i].req_ack));
      chk($sformatf("r%0d req_done", i), 64'(REQ_DONE), 64'(tbl[i].req_done));
      chk($sformatf("r%0d outstanding", i), 64'(OUTSTANDING), 64'(tbl[i].outst));
      chk($sformatf("r%0d err", i), 64'(ERR_UNDERFLOW), 64'(tbl[i].err));
      if (tbl[i].g >= 0) begin
        chk($sformatf("r%0d rx_addr", i), RX_ADDR, addrs[tbl[i].g]);
        chk($sformatf("r%0d rx_len", i), 64'(RX_LEN), 64'(lens[tbl[i].g]));
      end
    end

    // All four requesting, immediate ack, each grant completed in the following cycle.
    do_reset("rr");
    REQ = 4'b1111;
    RX_REQ_ACK = 1'b1;
    grants = 0;
    last = -1;
    exp_g = 0;
    dn = 1'b0;
    for (int c = 0; c < 320 && grants < 100; c++) begin
      @(posedge CLK);
      #1;
      RX_DONE = dn;
      dn = 1'b0;
      @(negedge CLK);
      if (REQ_ACK != '0) begin
        chk($sformatf("rr grant %0d", grants), 64'(REQ_ACK), 64'(1) << exp_g);
        if (last >= 0) chk($sformatf("rr spacing %0d", grants), 64'(c - last), 64'd3);
        last = c;
        exp_g = (exp_g + 1) % N;
        grants++;
        dn = 1'b1;
      end
    end
    chk("rr grant count", 64'(grants), 64'd100);

    // No completions: the tag FIFO fills after exactly D issues and stalls the arbiter.
    do_reset("full");
    REQ = 4'b1111;
    RX_REQ_ACK = 1'b1;
    acks = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge CLK);
      #1;
      @(negedge CLK);
      if (REQ_ACK != '0) acks++;
    end
    chk("full ack count", 64'(acks), 64'(D));
    chk("full rx_req", 64'(RX_REQ), 64'd0);
    chk("full outstanding", 64'(OUTSTANDING), 64'(D));
    @(posedge CLK);
    #1;
    RX_DONE = 1'b1;
    @(negedge CLK);
    chk("full done head", 64'(REQ_DONE), 64'b0001);
    @(posedge CLK);
    #1;
    RX_DONE = 1'b0;
    acks = 0;
    g = '0;
    for (int c = 0; c < 10; c++) begin
      @(posedge CLK);
      #1;
      @(negedge CLK);
      if (REQ_ACK != '0) begin
        acks++;
        g = REQ_ACK;
      end
    end
    chk("ninth ack count", 64'(acks), 64'd1);
    chk("ninth grant", 64'(g), 64'b0001);
    chk("ninth outstanding", 64'(OUTSTANDING), 64'(D));

    // Reset while a fourth request sits in ISSUE with three tags outstanding.
    do_reset("mid");
    REQ = 4'b1111;
    acks = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge CLK);
      #1;
      RX_REQ_ACK = acks < 3;
      @(negedge CLK);
      if (REQ_ACK != '0) acks++;
    end
    chk("mid ack count", 64'(acks), 64'd3);
    chk("mid rx_req held", 64'(RX_REQ), 64'd1);
    chk("mid rx_addr", RX_ADDR, addrs[3]);
    chk("mid outstanding", 64'(OUTSTANDING), 64'd3);
    do_reset("mid");
    @(posedge CLK);
    #1;
    RX_DONE = 1'b1;
    @(negedge CLK);
    chk("stale done pulse", 64'(REQ_DONE), 64'd0);
    @(posedge CLK);
    #1;
    RX_DONE = 1'b0;
    @(negedge CLK);
    chk("stale done err", 64'(ERR_UNDERFLOW), 64'd1);
    REQ = 4'b1111;
    RX_REQ_ACK = 1'b1;
    g = '0;
    for (int c = 0; c < 10 && g == '0; c++) begin
      @(posedge CLK);
      #1;
      @(negedge CLK);
      if (REQ_ACK != '0) g = REQ_ACK;
    end
    chk("post reset first grant", 64'(g), 64'b0001);
    chk("err stays sticky", 64'(ERR_UNDERFLOW), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
